// File: rtl/lisp.sv
// ---------------------------------------------------------------------------
// lisp -- shared definitions for the Lisp heap blocks.
//
// Holds the machine word width, the cell type tags, the number of heap words
// each kind of cell occupies, the allocator state encoding and the tag-to-size
// decode used by cell_allocator.
// ---------------------------------------------------------------------------
package lisp;

    localparam int data_width = 8;

    // Cell type tags, stored in the first word of every cell.
    localparam logic [data_width-1:0] TYPE_NIL    = 8'h00;
    localparam logic [data_width-1:0] TYPE_NUMBER = 8'h01;
    localparam logic [data_width-1:0] TYPE_CONS   = 8'h02;
    localparam logic [data_width-1:0] TYPE_SYMBOL = 8'h03;

    // Heap words per cell, tag word included.
    localparam logic [1:0] CELL_WORDS_NUMBER = 2'd2;  // tag, value
    localparam logic [1:0] CELL_WORDS_CONS   = 2'd3;  // tag, car, cdr
    localparam logic [1:0] CELL_WORDS_OTHER  = 2'd1;  // tag only

    typedef enum logic [2:0] {
        WAIT_BOOT,
        IDLE,
        WR_TAG,
        WR_W0,
        WR_W1,
        RESPOND
    } alloc_state_e;

    // Number of heap words a cell with the given tag occupies.
    function automatic logic [1:0] cell_size(input logic [data_width-1:0] tag);
        case (tag)
            TYPE_NUMBER: return CELL_WORDS_NUMBER;
            TYPE_CONS:   return CELL_WORDS_CONS;
            default:     return CELL_WORDS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/cell_allocator.sv
// ---------------------------------------------------------------------------
// cell_allocator -- bump-pointer allocator for Lisp heap cells.
//
// Accepts one cell at a time, checks it fits below the top of the heap,
// writes tag / word0 / word1 into memory_controller on consecutive cycles and
// returns the address of the tag word. A heap that cannot hold the cell
// answers with resp_full and leaves memory and the free pointer untouched.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   boot_done                 memory_controller finished its boot sequence
//   req_valid / req_ready     allocation request handshake
//   req_type                  cell tag (lisp::TYPE_*)
//   req_word0, req_word1      payload (NUMBER value; CONS car, cdr)
//   heap_clear                rewind the free pointer to HEAP_BASE (IDLE only)
//   resp_valid / resp_ready   completion handshake
//   resp_addr                 address of the new cell's tag word
//   resp_full                 request rejected, heap exhausted
//   mem_write_enable          write strobe to memory_controller
//   mem_read_enable           always 0, the allocator never reads
//   mem_addr, mem_write_data  write address / data to memory_controller
//   free_ptr                  next free address; 2**ADDR_WIDTH means full
// ---------------------------------------------------------------------------
module cell_allocator
    import lisp::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = data_width,
    parameter int HEAP_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_type,
    input  logic [DATA_WIDTH-1:0] req_word0,
    input  logic [DATA_WIDTH-1:0] req_word1,
    input  logic                  heap_clear,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_full,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [ADDR_WIDTH:0]   free_ptr
);

    // The free pointer carries one extra bit so "heap full" (2**ADDR_WIDTH)
    // is representable and the fit check cannot wrap.
    localparam int                PW          = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]     HEAP_LIMIT  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0]     HEAP_BASE_P = PW'(HEAP_BASE);

    alloc_state_e           state_q,      state_d;
    logic [PW-1:0]          free_ptr_q,   free_ptr_d;
    logic [DATA_WIDTH-1:0]  w0_q,         w0_d;
    logic [DATA_WIDTH-1:0]  w1_q,         w1_d;
    logic [1:0]             size_q,       size_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_full_q,  resp_full_d;
    logic [ADDR_WIDTH-1:0]  resp_addr_q,  resp_addr_d;
    logic                   mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q,  mem_wdata_d;

    logic [1:0]             req_size;
    logic [PW-1:0]          req_end;
    logic                   req_fits;
    logic                   more_words;

    // heap_clear takes priority over a request in the same cycle, so ready
    // must see it combinationally rather than a cycle late.
    assign req_ready = (state_q == IDLE) && !heap_clear;

    assign req_size = cell_size(data_width'(req_type));
    assign req_end  = free_ptr_q + PW'(req_size);
    assign req_fits = (req_end <= HEAP_LIMIT);

    // Another payload word follows the one just written.
    assign more_words = ((state_q == WR_TAG) && (size_q > 2'd1)) ||
                        ((state_q == WR_W0)  && (size_q > 2'd2));

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves a
        // signal unassigned -- that is what keeps this block free of latches.
        state_d      = state_q;
        free_ptr_d   = free_ptr_q;
        w0_d         = w0_q;
        w1_d         = w1_q;
        size_d       = size_q;
        resp_valid_d = resp_valid_q;
        resp_full_d  = resp_full_q;
        resp_addr_d  = resp_addr_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            WAIT_BOOT: begin
                if (boot_done) state_d = IDLE;
            end

            IDLE: begin
                if (heap_clear) begin
                    free_ptr_d = HEAP_BASE_P;
                end else if (req_valid) begin
                    w0_d        = req_word0;
                    w1_d        = req_word1;
                    size_d      = req_size;
                    resp_addr_d = free_ptr_q[ADDR_WIDTH-1:0];
                    resp_full_d = !req_fits;
                    if (req_fits) begin
                        // Tag write goes out the cycle after acceptance.
                        state_d     = WR_TAG;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = free_ptr_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = req_type;
                    end else begin
                        state_d      = RESPOND;
                        resp_valid_d = 1'b1;
                    end
                end
            end

            WR_TAG, WR_W0, WR_W1: begin
                if (more_words) begin
                    state_d     = (state_q == WR_TAG) ? WR_W0 : WR_W1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
                    mem_wdata_d = (state_q == WR_TAG) ? w0_q : w1_q;
                end else begin
                    state_d      = RESPOND;
                    resp_valid_d = 1'b1;
                    free_ptr_d   = free_ptr_q + PW'(size_q);
                end
            end

            RESPOND: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end

            default: state_d = WAIT_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_BOOT;
            free_ptr_q   <= HEAP_BASE_P;
            w0_q         <= '0;
            w1_q         <= '0;
            size_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_full_q  <= 1'b0;
            resp_addr_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            free_ptr_q   <= free_ptr_d;
            w0_q         <= w0_d;
            w1_q         <= w1_d;
            size_q       <= size_d;
            resp_valid_q <= resp_valid_d;
            resp_full_q  <= resp_full_d;
            resp_addr_q  <= resp_addr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_full        = resp_full_q;
    assign resp_addr        = resp_addr_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = 1'b0;
    assign mem_addr         = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;
    assign free_ptr         = free_ptr_q;

endmodule

// File: tb/tb_cell_allocator.sv
// ---------------------------------------------------------------------------
// tb_cell_allocator -- directed test for cell_allocator (ADDR_WIDTH=6).
// A small write-capture array stands in for memory_controller's RAM.
// ---------------------------------------------------------------------------
module tb_cell_allocator;
    import lisp::*;

    logic       clk;
    logic       rst;
    logic       boot_done;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_type;
    logic [7:0] req_word0;
    logic [7:0] req_word1;
    logic       heap_clear;
    logic       resp_valid;
    logic       resp_ready;
    logic [5:0] resp_addr;
    logic       resp_full;
    logic       mem_write_enable;
    logic       mem_read_enable;
    logic [5:0] mem_addr;
    logic [7:0] mem_write_data;
    logic [6:0] free_ptr;

    cell_allocator #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(8),
        .HEAP_BASE (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .boot_done       (boot_done),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_type        (req_type),
        .req_word0       (req_word0),
        .req_word1       (req_word1),
        .heap_clear      (heap_clear),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_addr       (resp_addr),
        .resp_full       (resp_full),
        .mem_write_enable(mem_write_enable),
        .mem_read_enable (mem_read_enable),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .free_ptr        (free_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         wr_count = 0;
    int         acc_q[$];
    logic [7:0] mem [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe on the falling edge: the values seen here are the ones the
    // next rising edge acts on.
    always @(negedge clk) begin
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (mem_write_enable) begin
            mem[mem_addr] <= mem_write_data;
            wr_count      <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with resp_ready=1; returns after the allocator is back in IDLE.
    task automatic send(input logic [7:0] t, input logic [7:0] w0, input logic [7:0] w1,
                        output logic [5:0] a, output logic f);
        int n;
        req_type  = t;
        req_word0 = w0;
        req_word1 = w1;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin tick(); n++; end
        check("send_ready_wait", 32'(n < 10), 32'd1);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin tick(); n++; end
        check("send_resp_wait", 32'(n < 10), 32'd1);
        a = resp_addr;
        f = resp_full;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] a;
        logic       f;
        int         w;
        int         c;
        int         n;

        rst        = 1'b0;
        boot_done  = 1'b0;
        req_valid  = 1'b0;
        req_type   = '0;
        req_word0  = '0;
        req_word1  = '0;
        heap_clear = 1'b0;
        resp_ready = 1'b1;

        // Reset values, before any clock edge.
        #3;
        check("rst_req_ready",  req_ready,        0);
        check("rst_resp_valid", resp_valid,       0);
        check("rst_resp_full",  resp_full,        0);
        check("rst_mem_we",     mem_write_enable, 0);
        check("rst_mem_re",     mem_read_enable,  0);
        check("rst_resp_addr",  resp_addr,        0);
        check("rst_mem_addr",   mem_addr,         0);
        check("rst_mem_wdata",  mem_write_data,   0);
        check("rst_free_ptr",   free_ptr,         0);

        tick(); tick();
        rst = 1'b1;

        // Request waiting while boot is not done.
        req_type  = TYPE_NUMBER;
        req_word0 = 8'h2A;
        req_word1 = 8'h00;
        req_valid = 1'b1;
        repeat (5) begin
            tick();
            check("boot_wait_ready", req_ready, 0);
        end
        check("boot_wait_nowrite", wr_count, 0);

        // boot_done: IDLE on the first edge, acceptance on the second.
        boot_done = 1'b1;
        tick(); tick();
        check("boot_accept", acc_q.size(), 1);
        req_valid = 1'b0;
        check("num_wr0_we",   mem_write_enable, 1);
        check("num_wr0_addr", mem_addr,         8'h00);
        check("num_wr0_data", mem_write_data,   TYPE_NUMBER);
        tick();
        check("num_wr1_we",   mem_write_enable, 1);
        check("num_wr1_addr", mem_addr,         8'h01);
        check("num_wr1_data", mem_write_data,   8'h2A);
        tick();
        check("num_resp_we",    mem_write_enable, 0);
        check("num_resp_valid", resp_valid,       1);
        check("num_resp_addr",  resp_addr,        8'h00);
        check("num_resp_full",  resp_full,        0);
        check("num_free_ptr",   free_ptr,         8'h02);
        tick();
        check("num_idle_valid", resp_valid, 0);
        check("num_idle_ready", req_ready,  1);
        check("num_mem0",  mem[0],   TYPE_NUMBER);
        check("num_mem1",  mem[1],   8'h2A);
        check("num_writes", wr_count, 2);

        // CONS car=0 cdr=0 lands at 0x02..0x04.
        w = wr_count;
        send(TYPE_CONS, 8'h00, 8'h00, a, f);
        check("cons_resp_addr", a, 8'h02);
        check("cons_resp_full", f, 0);
        check("cons_free_ptr",  free_ptr, 8'h05);
        check("cons_writes",    wr_count - w, 3);
        check("cons_mem2",      mem[2], TYPE_CONS);
        check("cons_mem3",      mem[3], 8'h00);
        check("cons_mem4",      mem[4], 8'h00);

        // Back-to-back NUMBERs: one acceptance every 4 cycles.
        c = acc_q.size();
        req_type  = TYPE_NUMBER;
        req_word0 = 8'h55;
        req_valid = 1'b1;
        n = 0;
        while (acc_q.size() < c + 3 && n < 40) begin tick(); n++; end
        check("tput_wait", 32'(n < 40), 32'd1);
        req_valid = 1'b0;
        n = 0;
        while (!req_ready && n < 10) begin tick(); n++; end
        check("tput_idle_wait", 32'(n < 10), 32'd1);
        check("tput_gap1", acc_q[c+1] - acc_q[c],   4);
        check("tput_gap2", acc_q[c+2] - acc_q[c+1], 4);
        check("tput_free_ptr", free_ptr, 8'h0B);
        check("tput_mem6",  mem[6],  8'h55);
        check("tput_mem10", mem[10], 8'h55);

        // Fill to 0x3E: 25 NUMBERs (50 words) and one NIL.
        for (int i = 0; i < 25; i++) send(TYPE_NUMBER, 8'(i), 8'h00, a, f);
        send(TYPE_NIL, 8'h00, 8'h00, a, f);
        check("fill_free_ptr", free_ptr, 8'h3E);

        // CONS does not fit (0x3E+3 > 0x40).
        w = wr_count;
        send(TYPE_CONS, 8'h01, 8'h02, a, f);
        check("full_cons_full",  f, 1);
        check("full_cons_addr",  a, 8'h3E);
        check("full_cons_fp",    free_ptr, 8'h3E);
        check("full_cons_nowr",  wr_count - w, 0);

        // NUMBER fits exactly.
        send(TYPE_NUMBER, 8'h77, 8'h00, a, f);
        check("exact_num_full", f, 0);
        check("exact_num_addr", a, 8'h3E);
        check("exact_num_fp",   free_ptr, 8'h40);
        check("exact_num_mem",  mem[63], 8'h77);

        // NIL on a completely full heap.
        send(TYPE_NIL, 8'h00, 8'h00, a, f);
        check("full_nil_full", f, 1);
        check("full_nil_addr", a, 8'h00);
        check("full_nil_fp",   free_ptr, 8'h40);

        // heap_clear with a pending request: clear first, accept next cycle.
        heap_clear = 1'b1;
        req_type   = TYPE_CONS;
        req_word0  = 8'h11;
        req_word1  = 8'h22;
        req_valid  = 1'b1;
        #1;
        check("clr_ready_low", req_ready, 0);
        c = acc_q.size();
        tick();
        check("clr_free_ptr", free_ptr, 8'h00);
        check("clr_no_accept", acc_q.size(), c);
        heap_clear = 1'b0;
        #1;
        check("clr_ready_high", req_ready, 1);
        tick();
        check("clr_accept", acc_q.size(), c + 1);
        req_valid = 1'b0;
        check("clr_wr_we",   mem_write_enable, 1);
        check("clr_wr_addr", mem_addr, 8'h00);
        n = 0;
        while (!resp_valid && n < 10) begin tick(); n++; end
        check("clr_resp_wait", 32'(n < 10), 32'd1);
        check("clr_resp_addr", resp_addr, 8'h00);
        check("clr_resp_fp",   free_ptr, 8'h03);
        tick();

        // Response held for 3 cycles; heap_clear there must be ignored.
        resp_ready = 1'b0;
        req_type   = TYPE_NUMBER;
        req_word0  = 8'h99;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("hold_enter_valid", resp_valid, 1);
        heap_clear = 1'b1;
        repeat (3) begin
            tick();
            check("hold_valid", resp_valid, 1);
            check("hold_addr",  resp_addr,  8'h03);
            check("hold_full",  resp_full,  0);
            check("hold_ready", req_ready,  0);
        end
        heap_clear = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("hold_release_valid", resp_valid, 0);
        check("hold_free_ptr",      free_ptr,   8'h05);
        check("hold_mem4",          mem[4],     8'h99);

        // Reset in the middle of a CONS write.
        req_type  = TYPE_CONS;
        req_word0 = 8'h33;
        req_word1 = 8'h44;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("abort_tag_addr", mem_addr,       8'h05);
        check("abort_tag_data", mem_write_data, TYPE_CONS);
        tick();
        check("abort_w0_we",   mem_write_enable, 1);
        check("abort_w0_addr", mem_addr,         8'h06);
        check("abort_w0_data", mem_write_data,   8'h33);
        rst = 1'b0;
        #1;
        check("abort_we",         mem_write_enable, 0);
        check("abort_free_ptr",   free_ptr,   8'h00);
        check("abort_req_ready",  req_ready,  0);
        check("abort_resp_valid", resp_valid, 0);
        w = wr_count;
        boot_done = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        check("abort_wait_boot", req_ready, 0);
        check("abort_no_write",  wr_count - w, 0);
        boot_done = 1'b1;
        tick();
        check("abort_reboot_ready", req_ready, 1);
        check("abort_reboot_fp",    free_ptr,  8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
